// File: rtl/wrap_queue.sv
// Circular in-order queue with wrap-around head/tail pointers, val/rdy enqueue and
// dequeue ports, and a synchronous flush. SIZE need not be a power of two.

module wrap_queue_inc #(
    parameter int SIZE     = 4,
    parameter int PTR_BITS = 2
) (
    input  logic [PTR_BITS-1:0] ptr_i,
    output logic [PTR_BITS-1:0] nxt_o
);
    localparam logic [PTR_BITS-1:0] LAST = PTR_BITS'(SIZE - 1);
    localparam logic [PTR_BITS-1:0] ONE  = PTR_BITS'(1);

    always_comb begin
        nxt_o = ptr_i + ONE;
        if (ptr_i == LAST) begin
            nxt_o = '0;
        end
    end
endmodule

module wrap_queue #(
    parameter int NBITS    = 8,
    parameter int SIZE     = 4,
    parameter int PTR_BITS = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              enq_val,
    output logic              enq_rdy,
    input  logic [NBITS-1:0]  enq_msg,
    output logic              deq_val,
    input  logic              deq_rdy,
    output logic [NBITS-1:0]  deq_msg,
    output logic [PTR_BITS:0] count
);
    // Handshake: a transfer happens on a rising edge when val and rdy are both high.
    // enq_rdy and deq_val depend only on registered occupancy, never on the peer's
    // val/rdy, so there is no pass-through when full and no bypass when empty.
    localparam logic [PTR_BITS:0] CNT_FULL = (PTR_BITS + 1)'(SIZE);
    localparam logic [PTR_BITS:0] CNT_ONE  = (PTR_BITS + 1)'(1);

    logic [PTR_BITS-1:0] head_q, head_d;
    logic [PTR_BITS-1:0] tail_q, tail_d;
    logic [PTR_BITS:0]   cnt_q, cnt_d;
    logic [NBITS-1:0]    mem_q [SIZE];

    logic [PTR_BITS-1:0] head_nxt;
    logic [PTR_BITS-1:0] tail_nxt;
    logic                enq_fire;
    logic                deq_fire;
    logic                do_write;

    wrap_queue_inc #(.SIZE(SIZE), .PTR_BITS(PTR_BITS)) u_head_inc (
        .ptr_i (head_q),
        .nxt_o (head_nxt)
    );

    wrap_queue_inc #(.SIZE(SIZE), .PTR_BITS(PTR_BITS)) u_tail_inc (
        .ptr_i (tail_q),
        .nxt_o (tail_nxt)
    );

    always_comb begin
        enq_rdy  = (cnt_q != CNT_FULL);
        deq_val  = (cnt_q != '0);
        deq_msg  = mem_q[head_q];
        count    = cnt_q;
        enq_fire = enq_val & enq_rdy;
        deq_fire = deq_val & deq_rdy;
    end

    // A flush drops whatever handshakes appear to complete in the same cycle.
    always_comb begin
        head_d   = head_q;
        tail_d   = tail_q;
        cnt_d    = cnt_q;
        do_write = 1'b0;
        if (clear) begin
            head_d = '0;
            tail_d = '0;
            cnt_d  = '0;
        end else begin
            if (enq_fire) begin
                tail_d   = tail_nxt;
                do_write = 1'b1;
            end
            if (deq_fire) begin
                head_d = head_nxt;
            end
            case ({enq_fire, deq_fire})
                2'b10:   cnt_d = cnt_q + CNT_ONE;
                2'b01:   cnt_d = cnt_q - CNT_ONE;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    // Payload storage carries no reset; occupancy alone says which slots are live.
    always_ff @(posedge clk) begin
        if (reset && do_write) begin
            mem_q[tail_q] <= enq_msg;
        end
    end
endmodule

// File: tb/tb_wrap_queue.sv
// Bench for wrap_queue: SIZE=4 and SIZE=3 instances share stimulus; a scoreboard
// queue holds expected payloads and a monitor checks each dequeue against it.

module tb_wrap_queue;
  logic       clk;
  logic       reset;
  logic       clear;
  logic       enq_val;
  logic [7:0] enq_msg;
  logic       deq_rdy;
  logic       sel;

  logic       enq_rdy4, deq_val4, enq_rdy3, deq_val3;
  logic [7:0] deq_msg4, deq_msg3;
  logic [2:0] count4, count3;

  wrap_queue #(.NBITS(8), .SIZE(4), .PTR_BITS(2)) dut4 (
    .clk(clk), .reset(reset), .clear(clear),
    .enq_val(enq_val), .enq_rdy(enq_rdy4), .enq_msg(enq_msg),
    .deq_val(deq_val4), .deq_rdy(deq_rdy), .deq_msg(deq_msg4), .count(count4)
  );

  wrap_queue #(.NBITS(8), .SIZE(3), .PTR_BITS(2)) dut3 (
    .clk(clk), .reset(reset), .clear(clear),
    .enq_val(enq_val), .enq_rdy(enq_rdy3), .enq_msg(enq_msg),
    .deq_val(deq_val3), .deq_rdy(deq_rdy), .deq_msg(deq_msg3), .count(count3)
  );

  wire       enq_rdy = sel ? enq_rdy3 : enq_rdy4;
  wire       deq_val = sel ? deq_val3 : deq_val4;
  wire [7:0] deq_msg = sel ? deq_msg3 : deq_msg4;
  wire [2:0] count   = sel ? count3 : count4;
  wire [1:0] head    = sel ? dut3.head_q : dut4.head_q;
  wire [1:0] tail    = sel ? dut3.tail_q : dut4.tail_q;

  logic [7:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int sz = 4;
  int mcnt = 0;
  int mhead = 0;
  int mtail = 0;
  bit mvalid = 0;

  // clock/reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic int winc(input int p);
    return (p == sz - 1) ? 0 : p + 1;
  endfunction

  // One clock cycle of stimulus; checks pre-edge outputs and updates the model.
  task automatic step(input logic ev, input logic [7:0] m, input logic dr,
                      input logic clr, input logic rst);
    bit e, d;
    enq_val = ev;
    enq_msg = m;
    deq_rdy = dr;
    clear   = clr;
    reset   = rst;
    @(negedge clk);
    if (mvalid) begin
      chk("count", int'(count), mcnt);
      chk("enq_rdy", int'(enq_rdy), (mcnt != sz) ? 1 : 0);
      chk("deq_val", int'(deq_val), (mcnt != 0) ? 1 : 0);
      chk("head", int'(head), mhead);
      chk("tail", int'(tail), mtail);
    end
    if (!rst || clr) begin
      exp_q.delete();
      mcnt = 0;
      mhead = 0;
      mtail = 0;
      mvalid = 1;
    end else begin
      e = ev && (mcnt != sz);
      d = dr && (mcnt != 0);
      if (e) begin
        exp_q.push_back(m);
        mtail = winc(mtail);
      end
      if (d) mhead = winc(mhead);
      mcnt = mcnt + int'(e) - int'(d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic [7:0] m);
    step(1'b1, m, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic deq();
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  // monitor: compares every accepted dequeue against the scoreboard
  initial begin
    logic [7:0] exp;
    forever begin
      @(negedge clk);
      #1;
      if (reset === 1'b1 && clear === 1'b0 && deq_val === 1'b1 && deq_rdy === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL deq_unexpected: got msg 0x%0h expected no dequeue at %0t", deq_msg, $time);
        end else begin
          exp = exp_q.pop_front();
          chk("deq_msg", int'(deq_msg), int'(exp));
        end
      end
    end
  end

  initial begin
    sel = 1'b0;
    enq_val = 1'b0;
    enq_msg = 8'h00;
    deq_rdy = 1'b0;
    clear = 1'b0;
    reset = 1'b0;

    // reset held two cycles with an enqueue attempt
    step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
    chk("rst_count", int'(count), 0);
    chk("rst_deq_val", int'(deq_val), 0);
    chk("rst_enq_rdy", int'(enq_rdy), 1);
    chk("rst_head", int'(head), 0);
    chk("rst_tail", int'(tail), 0);
    idle();

    // fill, overflow attempt, drain
    enq(8'h11); enq(8'h22); enq(8'h33); enq(8'h44);
    chk("full_count", int'(count), 4);
    chk("full_enq_rdy", int'(enq_rdy), 0);
    enq(8'h55);
    chk("full_after_extra", int'(count), 4);
    for (int i = 0; i < 4; i++) deq();
    chk("drained_deq_val", int'(deq_val), 0);
    chk("drained_sb", exp_q.size(), 0);
    idle();

    // wrap-around via single enq/deq pairs
    for (int i = 0; i < 6; i++) begin
      enq(8'hC0 + 8'(i));
      chk("wrap_count", int'(count), 1);
      deq();
    end
    chk("wrap_head", int'(head), 2);
    chk("wrap_tail", int'(tail), 2);

    // simultaneous enq/deq at count 2 and at full
    enq(8'hA1); enq(8'hA2);
    step(1'b1, 8'h77, 1'b1, 1'b0, 1'b1);
    chk("simul_count", int'(count), 2);
    deq(); deq();
    enq(8'hB1); enq(8'hB2); enq(8'hB3); enq(8'hB4);
    step(1'b1, 8'h88, 1'b1, 1'b0, 1'b1);
    chk("full_simul_count", int'(count), 3);
    deq(); deq(); deq();
    chk("simul_sb", exp_q.size(), 0);

    // clear mid-operation with a concurrent enqueue
    enq(8'hD1); enq(8'hD2); enq(8'hD3);
    step(1'b1, 8'h99, 1'b1, 1'b1, 1'b1);
    chk("clr_count", int'(count), 0);
    chk("clr_deq_val", int'(deq_val), 0);
    idle();
    enq(8'hE1); deq(); idle();

    // same again with reset in place of clear
    enq(8'hD4); enq(8'hD5); enq(8'hD6);
    step(1'b1, 8'h9A, 1'b1, 1'b0, 1'b0);
    chk("rstmid_count", int'(count), 0);
    chk("rstmid_deq_val", int'(deq_val), 0);
    idle();
    enq(8'hE2); deq(); idle();
    chk("phase1_sb", exp_q.size(), 0);

    // non-power-of-two instance
    sel = 1'b1;
    sz = 3;
    mvalid = 0;
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    idle();
    enq(8'h31); enq(8'h32); enq(8'h33);
    chk("s3_full_count", int'(count), 3);
    chk("s3_full_enq_rdy", int'(enq_rdy), 0);
    for (int i = 0; i < 5; i++) begin
      deq();
      chk("s3_enq_rdy_open", int'(enq_rdy), 1);
      enq(8'h40 + 8'(i));
      chk("s3_enq_rdy_full", int'(enq_rdy), 0);
    end
    deq(); deq(); deq();
    chk("s3_empty_deq_val", int'(deq_val), 0);
    chk("s3_sb", exp_q.size(), 0);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/wrap_queue.md
Name: wrap_queue

Overview:
- Circular FIFO buffer built around wrap-around head/tail pointer increment (ptr == SIZE-1 -> 0, else ptr+1).
- Downstream consumer of the wrap-increment function: instantiates one incrementer for head, one for tail.
- Used as the generic in-order queue (fetch buffer, free lists, ROB-style staging) with val/rdy enqueue and dequeue interfaces plus a synchronous clear for squash.

Parameters:
- NBITS, 8, payload width in bits.
- SIZE, 4, number of entries; any value >= 2, power of two not required.
- PTR_BITS, 2, pointer width; must satisfy 2^PTR_BITS >= SIZE.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset: state clears on a rising clk edge while reset == 0.
- clear  input  1  synchronous flush; empties the queue at the next edge.
- enq_val  input  1  enqueue request valid.
- enq_rdy  output  1  queue can accept an entry this cycle.
- enq_msg  input  NBITS  enqueue payload.
- deq_val  output  1  head entry valid.
- deq_rdy  input  1  consumer accepts head entry.
- deq_msg  output  NBITS  payload at head.
- count  output  PTR_BITS+1  number of occupied entries, 0..SIZE.

Behaviour:
- State: head, tail (PTR_BITS each), cnt (PTR_BITS+1), storage array SIZE x NBITS. Storage is not reset.
- Reset (reset == 0 at edge): head = 0, tail = 0, cnt = 0. Outputs after reset: enq_rdy = 1, deq_val = 0, count = 0. Reset overrides clear, enq and deq in the same cycle, and mid-operation contents are discarded.
- Output logic:
  - enq_rdy = (cnt != SIZE). Not dependent on deq_rdy: no pass-through when full.
  - deq_val = (cnt != 0). Not dependent on enq_val: no bypass when empty.
  - deq_msg = storage[head]. Don't-care while deq_val == 0; the bench must not check it.
  - count = cnt.
  - All outputs are functions of registered state only; no combinational input-to-output path.
- Fire conditions:
  - enq_fire = enq_val & enq_rdy.
  - deq_fire = deq_val & deq_rdy.
- Update at edge, when not in reset and clear == 0:
  - enq_fire: storage[tail] <= enq_msg; tail <= wrap_inc(tail).
  - deq_fire: head <= wrap_inc(head).
  - cnt <= cnt + enq_fire - deq_fire. Both firing leaves cnt unchanged.
- wrap_inc(p) = 0 if p == SIZE-1, else p+1. Pointers never hold values >= SIZE.
- clear == 1 (not in reset): head = 0, tail = 0, cnt = 0 at next edge. Any enq/deq in that cycle is dropped. Handshake outputs in the clear cycle still reflect current state, so a deq_fire may appear to occur but has no effect.
- Latency: an entry enqueued at edge N is visible on deq_val/deq_msg in the cycle after edge N (1 cycle). Full throughput of 1 enq + 1 deq per cycle when 0 < cnt < SIZE.
- Full (cnt == SIZE): head == tail, enq_rdy = 0, only deq can fire.
- Empty (cnt == 0): head == tail, deq_val = 0, only enq can fire.
- Illegal-free: enq_val while enq_rdy == 0 is ignored (no state change, no error).

Test Plan:
- Reset: hold reset = 0 for 2 cycles with enq_val = 1, enq_msg = 0xAA -> after release, count = 0, deq_val = 0, enq_rdy = 1, head = tail = 0.
- Fill/drain (SIZE=4): enqueue 0x11, 0x22, 0x33, 0x44 with deq_rdy = 0 -> count = 4, enq_rdy = 0; a 5th enqueue of 0x55 is ignored. Then deq_rdy = 1 for 4 cycles -> deq_msg sequence 0x11, 0x22, 0x33, 0x44, then deq_val = 0.
- Wrap-around: 6 single enq-then-deq pairs -> tail/head go 0,1,2,3,0,1,2; data order preserved; count never exceeds 1.
- Simultaneous: with count = 2, enq 0x77 and deq in the same cycle -> count stays 2, old head dequeued, 0x77 delivered after the remaining entry. At count = 4 with enq_val = deq_rdy = 1 -> only deq fires, count = 3.
- Clear/reset mid-operation: with count = 3, assert clear together with enq_val = 1 -> next cycle count = 0, deq_val = 0, enqueued data not delivered. Repeat with reset = 0 instead -> identical result.
- Non-power-of-two (SIZE=3, PTR_BITS=2): enqueue 3 entries, then stream 5 enq/deq pairs -> pointers cycle 0,1,2,0 and never reach 3; FIFO order correct; enq_rdy = 0 exactly when count = 3.
